// File: rtl/fxp_dot_acc_if.sv
// fxp_dot_acc_if: handshake bundle for the fixed-point dot-product accumulator.
//   Element side : in_valid/in_ready, fxp_i (Q8.8), wt_i (Q8.8), ovf_i
//   Result side  : out_valid/out_ready, acc_o (Q8.8), sat_o, ovf_o
// master = producer/consumer driving the block, slave = the block itself.
interface fxp_dot_acc_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] fxp_i;
    logic [15:0] wt_i;
    logic        ovf_i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] acc_o;
    logic        sat_o;
    logic        ovf_o;

    modport master (
        output in_valid, fxp_i, wt_i, ovf_i, out_ready,
        input  in_ready, out_valid, acc_o, sat_o, ovf_o
    );

    modport slave (
        input  in_valid, fxp_i, wt_i, ovf_i, out_ready,
        output in_ready, out_valid, acc_o, sat_o, ovf_o
    );
endinterface

// File: rtl/fxp_dot_acc.sv
// fxp_dot_acc: streaming Q8.8 x Q8.8 dot product over VEC_LEN element pairs.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fxp_dot_acc_if.slave (element input handshake, result output handshake)
// Pipeline: stage 1 registers the Q16.16 product, stage 2 accumulates into an
// ACC_W-bit accumulator. After the last element the FSM spends two DRAIN
// cycles letting the pipeline empty, then presents a rounded, saturated Q8.8
// result in HOLD until the consumer takes it.
module fxp_dot_acc #(
    parameter int VEC_LEN = 64,
    parameter int ACC_W   = 40
) (
    input logic           clk,
    input logic           rst,
    fxp_dot_acc_if.slave  bus
);
    localparam int CNT_W = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VEC_LEN - 1);

    localparam logic signed [ACC_W-1:0] RND_K  = {{(ACC_W-8){1'b0}}, 8'h80};
    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-16){1'b0}}, 16'h7FFF};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-16){1'b1}}, 16'h8000};

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic                     drn_q;
    logic signed [31:0]       prod_q;
    logic                     prod_vld_q;
    logic                     prod_first_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     ovf_stk_q;
    logic                     out_vld_q;
    logic [15:0]              acc_o_q;
    logic                     sat_o_q;
    logic                     ovf_o_q;

    logic in_rdy, xfer, first, last, ld_out, clr;

    // Handshake qualifiers
    assign xfer  = bus.in_valid && in_rdy;
    assign first = (cnt_q == '0);
    assign last  = (cnt_q == CNT_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (xfer)          state_d = ACCUM;
            ACCUM:   if (xfer && last)  state_d = DRAIN;
            DRAIN:   if (drn_q)         state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_rdy = (state_q == IDLE) || (state_q == ACCUM);
        // Second DRAIN cycle: the last product has reached acc_q.
        ld_out = (state_q == DRAIN) && drn_q;
        // Result handed off: wipe per-vector state before the next one.
        clr    = (state_q == HOLD) && bus.out_ready;
    end

    // ---------------- Datapath ----------------
    logic signed [31:0]      fxp_ext, wt_ext, prod_d;
    logic signed [ACC_W-1:0] prod_ext, rnd_sum, rnd;

    assign fxp_ext  = {{16{bus.fxp_i[15]}}, bus.fxp_i};
    assign wt_ext   = {{16{bus.wt_i[15]}},  bus.wt_i};
    assign prod_d   = fxp_ext * wt_ext;
    assign prod_ext = {{(ACC_W-32){prod_q[31]}}, prod_q};
    assign rnd_sum  = acc_q + RND_K;
    assign rnd      = rnd_sum >>> 8;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            drn_q        <= 1'b0;
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            acc_q        <= '0;
            ovf_stk_q    <= 1'b0;
        end else begin
            drn_q        <= (state_q == DRAIN) ? ~drn_q : 1'b0;
            prod_vld_q   <= xfer;
            prod_first_q <= xfer && first;
            if (xfer) prod_q <= prod_d;

            // Counter stops at VEC_LEN because in_ready drops in DRAIN.
            if (clr)       cnt_q <= '0;
            else if (xfer) cnt_q <= cnt_q + 1'b1;

            if (clr)
                acc_q <= '0;
            else if (prod_vld_q)
                acc_q <= prod_first_q ? prod_ext : acc_q + prod_ext;

            if (clr)       ovf_stk_q <= 1'b0;
            else if (xfer) ovf_stk_q <= first ? bus.ovf_i : (ovf_stk_q | bus.ovf_i);
        end
    end

    // ---------------- Result register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q <= 1'b0;
            acc_o_q   <= 16'h0000;
            sat_o_q   <= 1'b0;
            ovf_o_q   <= 1'b0;
        end else begin
            out_vld_q <= (state_d == HOLD);
            if (ld_out) begin
                ovf_o_q <= ovf_stk_q;
                if (rnd > SAT_HI) begin
                    acc_o_q <= 16'h7FFF;
                    sat_o_q <= 1'b1;
                end else if (rnd < SAT_LO) begin
                    acc_o_q <= 16'h8000;
                    sat_o_q <= 1'b1;
                end else begin
                    acc_o_q <= rnd[15:0];
                    sat_o_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld_q;
    assign bus.acc_o     = acc_o_q;
    assign bus.sat_o     = sat_o_q;
    assign bus.ovf_o     = ovf_o_q;
endmodule

// File: doc/fxp_dot_acc.md
FXP_DOT_ACC -- requirements
Module: fxp_dot_acc

Interface
REQ-001 SHALL have parameter VEC_LEN, default 64: number of element pairs per dot product (2..1024).
REQ-002 SHALL have parameter ACC_W, default 40: accumulator width in bits (>=40).
REQ-003 One clock; reset is asynchronous and active-high. The ports SHALL be named clk and rst.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1: fxp_i, wt_i and ovf_i are valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts an element this cycle.
REQ-008 SHALL have port fxp_i, input, 16: signed Q8.8 activation from the float-to-fixed converter.
REQ-009 SHALL have port wt_i, input, 16: signed Q8.8 weight.
REQ-010 SHALL have port ovf_i, input, 1: converter overflow flag for this element.
REQ-011 SHALL have port out_valid, output, 1: result is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port acc_o, output, 16: signed Q8.8 dot-product result.
REQ-014 SHALL have port sat_o, output, 1: result was saturated.
REQ-015 SHALL have port ovf_o, output, 1: sticky OR of ovf_i over the vector.

Function
REQ-016 An element SHALL transfer on a rising edge only when in_valid and in_ready are both 1.
REQ-017 The result SHALL transfer on a rising edge only when out_valid and out_ready are both 1.
REQ-018 FSM states SHALL be IDLE, ACCUM, DRAIN and HOLD.
REQ-019 IDLE -> ACCUM on the first transfer.
REQ-020 ACCUM -> DRAIN on the transfer that makes the element count equal VEC_LEN.
REQ-021 DRAIN -> HOLD after 2 cycles.
REQ-022 HOLD -> IDLE on the result transfer.
REQ-023 in_ready SHALL be 1 only in IDLE and ACCUM.
REQ-024 in_valid gaps SHALL stall the count without any effect on accumulation.
REQ-025 Stage 1 SHALL register the product fxp_i*wt_i as a 32-bit signed Q16.16 value.
REQ-026 Stage 2 SHALL sign-extend that product to ACC_W and add it to the accumulator.
REQ-027 The first element of a vector SHALL load the accumulator rather than add to it.
REQ-028 Output SHALL be computed as (acc + 0x80) arithmetic-shifted right by 8 (round half up).
REQ-029 If the rounded value is >32767, the output SHALL saturate to 0x7FFF with sat_o=1.
REQ-030 If the rounded value is <-32768, the output SHALL saturate to 0x8000 with sat_o=1.
REQ-031 Otherwise acc_o SHALL be the low 16 bits of the rounded value and sat_o SHALL be 0.
REQ-032 out_valid SHALL rise exactly 2 cycles after the VEC_LEN-th transfer (registered output).
REQ-033 acc_o, sat_o and ovf_o SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-034 out_valid SHALL drop on the cycle after the result transfer.
REQ-035 The next vector SHALL be accepted from the following cycle with the count, accumulator and ovf sticky cleared.
REQ-036 The element counter SHALL be clog2(VEC_LEN+1) bits wide and SHALL never wrap; it clears on entering IDLE.
REQ-037 ovf_i asserted on any accepted element SHALL set ovf_o for that vector's result only.
REQ-038 out_ready asserted outside HOLD SHALL have no effect.

Reset
REQ-039 rst=1 SHALL immediately force state=IDLE, counter=0, accumulator=0, pipeline valid bits=0, in_ready=1, out_valid=0, acc_o=0x0000, sat_o=0 and ovf_o=0.
REQ-040 Reset mid-vector or mid-HOLD SHALL discard partial results, with no result emitted for that vector.
REQ-041 The first transfer after rst is released SHALL start a fresh vector.

Verification (VEC_LEN=4 unless stated)
REQ-042 Scenario: 4x(0x0100,0x0100), out_ready=1 -> acc_o=0x0400, sat_o=0, ovf_o=0, out_valid 2 cycles after the 4th transfer.
REQ-043 Scenario: 4x(0x7FFF,0x7FFF) -> acc_o=0x7FFF, sat_o=1; then 4x(0x8000,0x7FFF) -> acc_o=0x8000, sat_o=1.
REQ-044 Scenario: (0x0001,0x0080) then 3x(0x0000,0x0000) -> acc_o=0x0001 (round half up); (0xFFFF,0x0080) then 3 zeros -> acc_o=0x0000.
REQ-045 Scenario: out_ready held 0 for 10 cycles in HOLD -> in_ready=0, acc_o stable, out_valid=1 throughout; then exactly one transfer.
REQ-046 Scenario: rst pulsed after 2 transfers, then 4x(0x0200,0x0100) -> single result 0x0800, no stale result.
REQ-047 Scenario: ovf_i=1 on 3rd element -> ovf_o=1; next clean vector -> ovf_o=0; random in_valid gaps give identical results.
